// File: rtl/dma_pkg.sv
// Shared constants and types for the shared-memory DMA arbiter.
// Holds memory geometry, the action encoding and the arbiter state type.
package dma_pkg;

  localparam int SIZE        = 4;   // shared-memory address width
  localparam int PROCSIZE    = 4;   // processor-local address / length width
  localparam int WORD_SIZE   = 8;
  localparam int PAGE_SIZE   = 2;   // ptr values below 2**PAGE_SIZE request an allocation
  localparam int PAGES_COUNT = 2 ** PAGE_SIZE;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } action_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } arb_state_t;

endpackage

// File: rtl/dma_request_arbiter_if.sv
// Command / completion channel between the arbiter and the DMA engine.
//   master : arbiter side (drives cmd_*, dma_abort; receives cmd_ready, dma_done, dma_ptr)
//   slave  : DMA engine side
interface dma_request_arbiter_if #(
  parameter int PROC_CNT = 4,
  parameter int SIZE     = dma_pkg::SIZE,
  parameter int PROCSIZE = dma_pkg::PROCSIZE
);
  localparam int IDX_W = $clog2(PROC_CNT);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IDX_W-1:0]    cmd_proc;
  logic                cmd_action;
  logic [SIZE-1:0]     cmd_ptr;
  logic [PROCSIZE-1:0] cmd_copy_start;
  logic [PROCSIZE-1:0] cmd_copy_length;
  logic                dma_done;
  logic [SIZE-1:0]     dma_ptr;
  logic                dma_abort;

  modport master (
    output cmd_valid, cmd_proc, cmd_action, cmd_ptr, cmd_copy_start, cmd_copy_length, dma_abort,
    input  cmd_ready, dma_done, dma_ptr
  );

  modport slave (
    input  cmd_valid, cmd_proc, cmd_action, cmd_ptr, cmd_copy_start, cmd_copy_length, dma_abort,
    output cmd_ready, dma_done, dma_ptr
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   pending     : per-processor outstanding request
//   rr_last     : index served most recently (lowest priority)
//   grant_valid : some request is pending
//   grant_idx   : first pending index after rr_last, wrapping modulo PROC_CNT
module rr_priority_picker #(
  parameter int PROC_CNT = 4,
  parameter int IDX_W    = $clog2(PROC_CNT)
) (
  input  logic [PROC_CNT-1:0] pending,
  input  logic [IDX_W-1:0]    rr_last,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx
);

  // Scan from the farthest offset down to the nearest so the closest
  // pending index after rr_last is the last one assigned.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = PROC_CNT; k >= 1; k--) begin
      if (pending[IDX_W'((int'(rr_last) + k) % PROC_CNT)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(rr_last) + k) % PROC_CNT);
      end
    end
  end

endmodule

// File: rtl/dma_request_arbiter.sv
// Shares one DMA engine among PROC_CNT processors using toggle handshakes.
//   clock, reset          : system clock, synchronous active-high reset
//   trigger / ack         : per-processor request / completion toggles
//   action, ptr,
//   copy_start, copy_length : per-processor command, sampled only at grant
//   ptr_out               : pointer returned by each processor's last completed command
//   err                   : sticky per-processor timeout flag
//   dma                   : command/completion channel to the DMA engine
//
// state | meaning
// IDLE  | waiting for a pending request; grants round-robin
// ISSUE | cmd_valid high, cmd_* held until cmd_ready
// BUSY  | command accepted, waiting for dma_done or watchdog expiry
module dma_request_arbiter #(
  parameter int PROC_CNT = 4,
  parameter int SIZE     = dma_pkg::SIZE,
  parameter int PROCSIZE = dma_pkg::PROCSIZE,
  parameter int TIMEOUT  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_CNT-1:0] trigger,
  output logic [PROC_CNT-1:0] ack,
  input  logic [PROC_CNT-1:0] action,
  input  logic [SIZE-1:0]     ptr         [PROC_CNT],
  input  logic [PROCSIZE-1:0] copy_start  [PROC_CNT],
  input  logic [PROCSIZE-1:0] copy_length [PROC_CNT],
  output logic [SIZE-1:0]     ptr_out     [PROC_CNT],
  output logic [PROC_CNT-1:0] err,
  dma_request_arbiter_if.master dma
);
  import dma_pkg::*;

  localparam int IDX_W = $clog2(PROC_CNT);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  arb_state_t          state;
  logic [IDX_W-1:0]    rr_last;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [TMR_W-1:0]    timer;
  logic [PROC_CNT-1:0] pending;

  assign pending = trigger ^ ack;

  rr_priority_picker #(.PROC_CNT(PROC_CNT), .IDX_W(IDX_W)) u_picker (
    .pending     (pending),
    .rr_last     (rr_last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      rr_last             <= IDX_W'(PROC_CNT - 1);
      timer               <= '0;
      ack                 <= '0;
      err                 <= '0;
      for (int i = 0; i < PROC_CNT; i++) ptr_out[i] <= '0;
      dma.cmd_valid       <= 1'b0;
      dma.cmd_proc        <= '0;
      dma.cmd_action      <= 1'b0;
      dma.cmd_ptr         <= '0;
      dma.cmd_copy_start  <= '0;
      dma.cmd_copy_length <= '0;
      dma.dma_abort       <= 1'b0;
    end else begin
      dma.dma_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            dma.cmd_proc        <= grant_idx;
            dma.cmd_action      <= action[grant_idx];
            dma.cmd_ptr         <= ptr[grant_idx];
            dma.cmd_copy_start  <= copy_start[grant_idx];
            dma.cmd_copy_length <= copy_length[grant_idx];
            dma.cmd_valid       <= 1'b1;
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          if (dma.cmd_valid && dma.cmd_ready) begin
            dma.cmd_valid <= 1'b0;
            timer         <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (timer != TMR_MAX) timer <= timer + 1'b1;
          // done takes precedence over a watchdog expiry in the same cycle
          if (dma.dma_done) begin
            ptr_out[dma.cmd_proc] <= dma.dma_ptr;
            ack[dma.cmd_proc]     <= ~ack[dma.cmd_proc];
            rr_last               <= dma.cmd_proc;
            state                 <= IDLE;
          end else if (timer == TMR_LAST) begin
            dma.dma_abort     <= 1'b1;
            err[dma.cmd_proc] <= 1'b1;
            ack[dma.cmd_proc] <= ~ack[dma.cmd_proc];
            rr_last           <= dma.cmd_proc;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_request_arbiter.sv
module tb_dma_request_arbiter;
  localparam int P  = 4;
  localparam int S  = 4;
  localparam int PS = 4;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [P-1:0]  trigger, action, ack, err;
  logic [S-1:0]  ptr         [P];
  logic [PS-1:0] copy_start  [P];
  logic [PS-1:0] copy_length [P];
  logic [S-1:0]  ptr_out     [P];

  dma_request_arbiter_if #(.PROC_CNT(P), .SIZE(S), .PROCSIZE(PS)) bus ();

  dma_request_arbiter #(.PROC_CNT(P), .SIZE(S), .PROCSIZE(PS), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .trigger     (trigger),
    .ack         (ack),
    .action      (action),
    .ptr         (ptr),
    .copy_start  (copy_start),
    .copy_length (copy_length),
    .ptr_out     (ptr_out),
    .err         (err),
    .dma         (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: 0 = no owner, 1 = command offered, 2 = command in flight
  int           m_stage   = 0;
  int           m_owner   = 0;
  int           m_rr      = P - 1;
  int           m_age     = 0;
  int           m_done_at = 0;
  logic [P-1:0] m_ack     = '0;
  logic [P-1:0] m_err     = '0;
  logic [S-1:0] m_ptr_out [P];
  logic         e_valid, e_action, e_abort;
  logic [1:0]   e_proc;
  logic [S-1:0] e_ptr;
  logic [PS-1:0] e_cs, e_cl;

  // Stimulus knobs
  int           trig_pct  = 0;
  int           ready_pct = 100;
  int           done_mode = 0;  // 0 short, 1 never, 2 at watchdog edge, 4 mixed
  int           stray_pct = 0;
  logic         fix_dptr  = 1'b0;
  logic [S-1:0] dptr_val  = '0;

  int   abort_cnt  = 0;
  int   grant_log[$];
  logic prev_valid = 1'b0;

  task automatic drive();
    if (!reset) begin
      for (int i = 0; i < P; i++) begin
        if ((trigger[i] ^ m_ack[i]) == 1'b0 && $urandom_range(99) < trig_pct) begin
          trigger[i]     = ~trigger[i];
          action[i]      = 1'($urandom);
          ptr[i]         = S'($urandom);
          copy_start[i]  = PS'($urandom);
          copy_length[i] = PS'($urandom);
        end
      end
    end
    bus.cmd_ready = ($urandom_range(99) < ready_pct);
    if (m_stage == 2) bus.dma_done = (m_age >= m_done_at) && (done_mode != 1);
    else              bus.dma_done = ($urandom_range(99) < stray_pct);
    bus.dma_ptr = fix_dptr ? dptr_val : S'($urandom);
  endtask

  task automatic model_step();
    if (reset) begin
      m_stage = 0; m_rr = P - 1; m_ack = '0; m_err = '0;
      for (int i = 0; i < P; i++) m_ptr_out[i] = '0;
      e_valid = 0; e_action = 0; e_abort = 0; e_proc = '0; e_ptr = '0; e_cs = '0; e_cl = '0;
    end else begin
      e_abort = 1'b0;
      case (m_stage)
        0: begin
          for (int k = 1; k <= P; k++) begin
            int idx;
            idx = (m_rr + k) % P;
            if (trigger[idx] ^ m_ack[idx]) begin
              m_owner = idx; e_proc = 2'(idx); e_action = action[idx];
              e_ptr = ptr[idx]; e_cs = copy_start[idx]; e_cl = copy_length[idx];
              e_valid = 1'b1; m_stage = 1;
              break;
            end
          end
        end
        1: begin
          if (bus.cmd_ready) begin
            e_valid = 1'b0; m_stage = 2; m_age = 0;
            case (done_mode)
              1: m_done_at = TO + 5;
              2: m_done_at = TO - 1;
              4: begin
                int r;
                r = int'($urandom_range(9));
                m_done_at = (r == 0) ? TO + 5 : (r == 1) ? TO - 1 : int'($urandom_range(6));
              end
              default: m_done_at = int'($urandom_range(6));
            endcase
          end
        end
        default: begin
          if (bus.dma_done) begin
            m_ptr_out[m_owner] = bus.dma_ptr;
            m_ack[m_owner] = ~m_ack[m_owner];
            m_rr = m_owner; m_stage = 0;
          end else if (m_age == TO - 1) begin
            e_abort = 1'b1;
            m_err[m_owner] = 1'b1;
            m_ack[m_owner] = ~m_ack[m_owner];
            m_rr = m_owner; m_stage = 0;
          end else begin
            m_age++;
          end
        end
      endcase
    end
  endtask

  task automatic compare();
    check_val("cmd_valid", bus.cmd_valid, e_valid);
    check_val("cmd_proc", bus.cmd_proc, e_proc);
    check_val("cmd_action", bus.cmd_action, e_action);
    check_val("cmd_ptr", bus.cmd_ptr, e_ptr);
    check_val("cmd_copy_start", bus.cmd_copy_start, e_cs);
    check_val("cmd_copy_length", bus.cmd_copy_length, e_cl);
    check_val("dma_abort", bus.dma_abort, e_abort);
    check_val("ack", ack, m_ack);
    check_val("err", err, m_err);
    for (int i = 0; i < P; i++) check_val($sformatf("ptr_out%0d", i), ptr_out[i], m_ptr_out[i]);
    if (bus.cmd_valid === 1'b1 && !prev_valid) grant_log.push_back(int'(bus.cmd_proc));
    prev_valid = (bus.cmd_valid === 1'b1);
    if (bus.dma_abort === 1'b1) abort_cnt++;
  endtask

  task automatic cycle();
    @(negedge clock);
    drive();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trigger = '0;
    cycle();
    reset = 1'b0;
  endtask

  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int exp_to[2] = '{3, 0};

  initial begin
    trigger = '0; action = '0;
    for (int i = 0; i < P; i++) begin ptr[i] = '0; copy_start[i] = '0; copy_length[i] = '0; end
    bus.cmd_ready = 1'b0; bus.dma_done = 1'b0; bus.dma_ptr = '0;
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    check_val("rst_ack", ack, 0);
    check_val("rst_err", err, 0);
    check_val("rst_cmd_valid", bus.cmd_valid, 0);
    check_val("rst_abort", bus.dma_abort, 0);

    // single request from processor 2
    trigger[2] = 1'b1; action[2] = 1'b1; ptr[2] = 4'h0; copy_start[2] = 4'h3; copy_length[2] = 4'h5;
    fix_dptr = 1'b1; dptr_val = 4'h8;
    cycle();
    check_val("t1_valid", bus.cmd_valid, 1);
    check_val("t1_proc", bus.cmd_proc, 2);
    check_val("t1_len", bus.cmd_copy_length, 5);
    repeat (12) cycle();
    check_val("t1_ack2", ack[2], 1);
    check_val("t1_ptr_out2", ptr_out[2], 8);
    fix_dptr = 1'b0;

    // round-robin from reset priority
    do_reset();
    grant_log.delete();
    for (int i = 0; i < P; i++) begin
      trigger[i] = ~trigger[i]; action[i] = 1'($urandom); ptr[i] = S'($urandom);
      copy_start[i] = PS'($urandom); copy_length[i] = PS'($urandom);
    end
    repeat (60) cycle();
    trigger[0] = ~trigger[0];
    trigger[1] = ~trigger[1];
    repeat (30) cycle();
    check_val("rr_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) check_val($sformatf("rr_grant%0d", i), grant_log[i], exp_rr[i]);

    // backpressure with stray dma_done while the command is still offered
    ready_pct = 0; stray_pct = 50;
    trigger[1] = ~trigger[1]; copy_length[1] = 4'hA;
    repeat (6) cycle();
    check_val("bp_valid_held", bus.cmd_valid, 1);
    check_val("bp_proc", bus.cmd_proc, 1);
    check_val("bp_len", bus.cmd_copy_length, 4'hA);
    stray_pct = 0; ready_pct = 100;
    repeat (15) cycle();

    // watchdog: processor 3 hangs, processor 0 is served afterwards
    grant_log.delete();
    abort_cnt = 0;
    done_mode = 1;
    trigger[3] = ~trigger[3];
    trigger[0] = ~trigger[0];
    for (int c = 0; c < TO + 20 && abort_cnt == 0; c++) cycle();
    done_mode = 0;
    repeat (20) cycle();
    check_val("to_abort_once", abort_cnt, 1);
    check_val("to_err3", err[3], 1);
    check_val("to_err0", err[0], 0);
    check_val("to_grants", grant_log.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < grant_log.size()) check_val($sformatf("to_grant%0d", i), grant_log[i], exp_to[i]);

    // done arrives on the watchdog edge
    done_mode = 2; fix_dptr = 1'b1; dptr_val = 4'hB;
    trigger[2] = ~trigger[2];
    repeat (TO + 12) cycle();
    check_val("col_no_abort", abort_cnt, 1);
    check_val("col_err2", err[2], 0);
    check_val("col_ptr_out2", ptr_out[2], 4'hB);
    fix_dptr = 1'b0;

    // reset while in flight, then a stale done
    done_mode = 1;
    trigger[1] = ~trigger[1];
    repeat (6) cycle();
    do_reset();
    check_val("mid_rst_ack", ack, 0);
    check_val("mid_rst_err", err, 0);
    check_val("mid_rst_valid", bus.cmd_valid, 0);
    check_val("mid_rst_ptr_out2", ptr_out[2], 0);
    stray_pct = 100;
    repeat (3) cycle();
    check_val("stale_done_ack", ack, 0);
    check_val("stale_done_ptr_out1", ptr_out[1], 0);

    // randomized traffic
    stray_pct = 10; done_mode = 4; trig_pct = 30; ready_pct = 60;
    repeat (3000) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
